// File: rtl/dtw_ref_streamer.sv
// -----------------------------------------------------------------------------
// dtw_ref_streamer
//
// Reads one full sweep of the DTW reference memory (samples 0..len-1) on each
// accepted start pulse. The samples go out as a valid/ready stream, and tlast
// marks the final sample. Addresses are issued only while the output FIFO has
// room for every read in flight. Because of this, backpressure never causes
// data loss and the stream keeps up one beat per cycle when ready is held high.
//
// Ports:
//   clk_in, rst_in         clock, asynchronous active-high reset
//   start_in               one-cycle pulse: begin a sweep (accepted in IDLE only)
//   abort_in               cancel the sweep in progress (flushes everything)
//   ref_ready_in           reference memory loaded; sampled only at start
//   ref_len_in             number of reference samples (clamped to 2^PTR)
//   ref_addr_out           reference-memory read address
//   ref_data_in            reference-memory read data, MEM_LATENCY after addr
//   ref_tdata_out          stream sample
//   ref_tvalid_out         stream valid
//   ref_tready_in          stream ready
//   ref_tlast_out          final sample of the sweep
//   busy_out               sweep in progress
//   done_out               one-cycle pulse: sweep complete
//   len_err_out            sticky: ref_len was clamped, cleared on next start
//   dbg_state              FSM state
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start_in with ref_ready_in
// STREAM | issuing addresses 0..len-1 under FIFO credit
// DRAIN  | all addresses issued; waiting for the FIFO and pipeline to empty
// -----------------------------------------------------------------------------
module dtw_ref_streamer #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 32,
    parameter int REFMEM_PTR_WIDTH = 20,
    parameter int MEM_LATENCY      = 2,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic                        abort_in,
    input  logic                        ref_ready_in,
    input  logic [ADDR_WIDTH-1:0]       ref_len_in,
    output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
    input  logic [DATA_WIDTH-1:0]       ref_data_in,
    output logic [DATA_WIDTH-1:0]       ref_tdata_out,
    output logic                        ref_tvalid_out,
    input  logic                        ref_tready_in,
    output logic                        ref_tlast_out,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        len_err_out,
    output logic [1:0]                  dbg_state
);

    if (FIFO_DEPTH < MEM_LATENCY + 1) begin : g_depth_check
        $error("dtw_ref_streamer: FIFO_DEPTH must be >= MEM_LATENCY+1");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_latency_check
        $error("dtw_ref_streamer: MEM_LATENCY must be in 1..4");
    end
    if (ADDR_WIDTH <= REFMEM_PTR_WIDTH) begin : g_width_check
        $error("dtw_ref_streamer: ADDR_WIDTH must exceed REFMEM_PTR_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // One extra bit so that len = 2^PTR is representable without wrap.
    localparam int CNT_W  = REFMEM_PTR_WIDTH + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int INF_W  = $clog2(MEM_LATENCY + 1);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + MEM_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LEN_MAX = ADDR_WIDTH'(1) << REFMEM_PTR_WIDTH;

    state_t                  state_q, state_d;
    logic                    done_d;
    logic                    done_q;
    logic [CNT_W-1:0]        len_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    len_err_q;

    logic                    len_over;
    logic [CNT_W-1:0]        len_sel;
    logic                    start_ok;
    logic                    flush;
    logic                    issue;
    logic                    last_issue;
    logic                    drain_done;

    logic [MEM_LATENCY-1:0]  tok_sr;
    logic [MEM_LATENCY-1:0]  last_sr;
    logic [INF_W-1:0]        inflight;
    logic [OCC_W-1:0]        occupancy;

    logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
    logic                    fifo_last [FIFO_DEPTH];
    logic [FPTR_W-1:0]       wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]       fifo_count;
    logic                    fifo_wr;
    logic                    fifo_rd;

    // ---------------------------------------------------------------------
    // Datapath control
    // ---------------------------------------------------------------------
    always_comb begin
        len_over = (ref_len_in > LEN_MAX);
        len_sel  = len_over ? LEN_MAX[CNT_W-1:0] : ref_len_in[CNT_W-1:0];
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + INF_W'(tok_sr[i]);
        end
    end

    // Abort outranks start, so it also blocks a start that arrives in IDLE.
    assign start_ok   = (state_q == ST_IDLE) && start_in && ref_ready_in && !abort_in;
    assign flush      = abort_in && (state_q != ST_IDLE);
    // Credit counts FIFO entries plus reads still in the memory pipeline,
    // so a write always has a free slot when its token emerges.
    assign occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight);
    assign issue      = (state_q == ST_STREAM) && !abort_in &&
                        (occupancy < OCC_W'(FIFO_DEPTH));
    assign last_issue = issue && (cnt_q == len_q - CNT_W'(1));

    assign ref_tvalid_out = (fifo_count != '0);
    assign fifo_rd        = ref_tvalid_out && ref_tready_in;
    assign fifo_wr        = tok_sr[MEM_LATENCY-1];

    // Completion is detected on the edge where the final beat transfers.
    // Because of this, done, IDLE and busy=0 show up together in the cycle
    // after the last beat.
    assign drain_done = (inflight == '0) &&
                        ((fifo_count == '0) ||
                         ((fifo_count == FCNT_W'(1)) && fifo_rd));

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (len_sel == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else if (drain_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Issue counter / length latch
    // The counter stops on the last address, so ref_addr_out holds that
    // address until the next sweep starts.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            len_q     <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else if (start_ok) begin
            len_q     <= len_sel;
            cnt_q     <= '0;
            len_err_q <= len_over;
        end else if (issue && !last_issue) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Read-latency token pipeline, with the tlast flag carried alongside
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tok_sr  <= '0;
            last_sr <= '0;
        end else if (flush) begin
            tok_sr  <= '0;
            last_sr <= '0;
        end else begin
            tok_sr[0]  <= issue;
            last_sr[0] <= last_issue;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tok_sr[i]  <= tok_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    // ---------------------------------------------------------------------
    // First-word-fall-through output FIFO
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= (wr_ptr == FPTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + FPTR_W'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= (rd_ptr == FPTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + FPTR_W'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (fifo_wr && !flush) begin
            fifo_data[wr_ptr] <= ref_data_in;
            fifo_last[wr_ptr] <= last_sr[MEM_LATENCY-1];
        end
    end

    // Payload is forced to zero while the FIFO is empty. This keeps the
    // outputs at zero right after reset, even though the storage array
    // itself is never reset.
    assign ref_tdata_out = ref_tvalid_out ? fifo_data[rd_ptr] : '0;
    assign ref_tlast_out = ref_tvalid_out && fifo_last[rd_ptr];

    assign ref_addr_out = cnt_q[REFMEM_PTR_WIDTH-1:0];
    assign busy_out     = (state_q != ST_IDLE);
    assign done_out     = done_q;
    assign len_err_out  = len_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dtw_ref_streamer.sv
// -----------------------------------------------------------------------------
// Directed bench for dtw_ref_streamer. The reference memory is modelled with
// two read pipeline stages and holds mem[i] = 0x100 + i. REFMEM_PTR_WIDTH is 4,
// so the length clamp can be exercised.
// -----------------------------------------------------------------------------
module tb_dtw_ref_streamer;

    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int PW    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in, abort_in, ref_ready_in, ref_tready_in;
    logic [AW-1:0] ref_len_in;
    logic [PW-1:0] ref_addr_out;
    logic [DW-1:0] ref_data_in;
    logic [DW-1:0] ref_tdata_out;
    logic          ref_tvalid_out, ref_tlast_out, busy_out, done_out, len_err_out;
    logic [1:0]    dbg_state;

    dtw_ref_streamer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REFMEM_PTR_WIDTH(PW),
        .MEM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
        .ref_ready_in(ref_ready_in), .ref_len_in(ref_len_in),
        .ref_addr_out(ref_addr_out), .ref_data_in(ref_data_in),
        .ref_tdata_out(ref_tdata_out), .ref_tvalid_out(ref_tvalid_out),
        .ref_tready_in(ref_tready_in), .ref_tlast_out(ref_tlast_out),
        .busy_out(busy_out), .done_out(done_out), .len_err_out(len_err_out),
        .dbg_state(dbg_state)
    );

    always #5 clk_in = ~clk_in;

    // reference memory: registered address, registered data
    logic [DW-1:0] mem [16];
    logic [PW-1:0] mem_addr_q;
    always @(posedge clk_in) begin
        mem_addr_q  <= ref_addr_out;
        ref_data_in <= mem[mem_addr_q];
    end

    int n_total = 0;
    int n_bad   = 0;
    int ovf     = 0;

    always @(posedge clk_in) begin
        if (!rst_in && dut.fifo_wr && !dut.fifo_rd && !dut.flush &&
            dut.fifo_count == 3'(DEPTH))
            ovf++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_start(input int len, input logic rdy);
        ref_len_in   = AW'(len);
        ref_ready_in = rdy;
        start_in     = 1'b1;
        tick();
        start_in     = 1'b0;
    endtask

    int beats[$];
    int ntlast, last_idx, dones, first_k, done_k, stall_bad, busy_bad;

    // Call right after do_start. Sample k=1 is the first one after the start
    // edge. The loop ends on done_out or when maxcyc runs out.
    task automatic run(input int maxcyc, input bit rnd);
        logic          p_stall;
        logic [DW-1:0] p_data;
        logic          p_last;
        beats.delete();
        ntlast = 0; last_idx = -1; dones = 0; first_k = -1; done_k = -1;
        stall_bad = 0; busy_bad = 0; p_stall = 1'b0; p_data = '0; p_last = 1'b0;
        for (int k = 1; k <= maxcyc && dones == 0; k++) begin
            ref_tready_in = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (p_stall && (!ref_tvalid_out || ref_tdata_out !== p_data || ref_tlast_out !== p_last))
                stall_bad++;
            if (ref_tvalid_out && first_k < 0) first_k = k;
            if (ref_tvalid_out && ref_tready_in) begin
                beats.push_back(int'(ref_tdata_out));
                if (ref_tlast_out) begin
                    ntlast++;
                    last_idx = beats.size() - 1;
                end
            end
            if (done_out) begin
                dones++;
                done_k = k;
            end else if (!busy_out) begin
                busy_bad++;
            end
            p_stall = ref_tvalid_out && !ref_tready_in;
            p_data  = ref_tdata_out;
            p_last  = ref_tlast_out;
            if (dones == 0) tick();
        end
        ref_tready_in = 1'b1;
    endtask

    task automatic chk_beats(input string tag, input int n);
        chk({tag, "_nbeats"}, beats.size(), n);
        for (int i = 0; i < n; i++)
            chk({tag, "_beat"}, (i < beats.size()) ? beats[i] : 32'hDEAD, 32'h100 + i);
        chk({tag, "_ntlast"}, ntlast, (n > 0) ? 1 : 0);
        chk({tag, "_tlast_idx"}, last_idx, n - 1);
        chk({tag, "_dones"}, dones, 1);
    endtask

    int extra;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'(16'h100 + i);
        rst_in = 1'b1; start_in = 1'b0; abort_in = 1'b0; ref_ready_in = 1'b0;
        ref_tready_in = 1'b1; ref_len_in = '0;
        tick(); tick();
        chk("rst_tvalid", ref_tvalid_out, 0);
        chk("rst_busy",   busy_out, 0);
        chk("rst_done",   done_out, 0);
        chk("rst_lenerr", len_err_out, 0);
        chk("rst_state",  dbg_state, 0);
        chk("rst_addr",   ref_addr_out, 0);
        chk("rst_tdata",  ref_tdata_out, 0);
        chk("rst_tlast",  ref_tlast_out, 0);
        rst_in = 1'b0;
        tick();

        // 1: len=5, tready held high
        do_start(5, 1'b1);
        chk("t1_busy_k1", busy_out, 1);
        chk("t1_state_k1", dbg_state, 1);
        run(40, 1'b0);
        chk_beats("t1", 5);
        chk("t1_first_k", first_k, 4);
        chk("t1_done_k", done_k, 9);
        chk("t1_busy_hi", busy_bad, 0);
        chk("t1_busy_end", busy_out, 0);
        chk("t1_state_end", dbg_state, 0);
        chk("t1_addr_hold", ref_addr_out, 4);
        tick();
        chk("t1_done_pulse", done_out, 0);

        // 2: len=12, random backpressure
        do_start(12, 1'b1);
        run(300, 1'b1);
        chk_beats("t2", 12);
        chk("t2_stall_stable", stall_bad, 0);
        extra = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (done_out) extra++; end
        chk("t2_extra_done", extra, 0);

        // 3: len=0, then start without ref_ready
        do_start(0, 1'b1);
        run(10, 1'b0);
        chk("t3_len0_beats", beats.size(), 0);
        chk("t3_len0_first", first_k, -1);
        chk("t3_len0_done_k", done_k, 1);
        do_start(5, 1'b0);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy_out || ref_tvalid_out || done_out) extra++;
            tick();
        end
        chk("t3_noready_quiet", extra, 0);

        // 4: len=8, stall after 3 beats, abort at cycle 10
        do_start(8, 1'b1);
        beats.delete(); dones = 0;
        for (int k = 1; k <= 10; k++) begin
            ref_tready_in = (k <= 6);
            if (ref_tvalid_out && ref_tready_in) beats.push_back(int'(ref_tdata_out));
            if (done_out) dones++;
            if (k < 10) tick();
        end
        chk("t4_pre_nbeats", beats.size(), 3);
        chk("t4_pre_valid", ref_tvalid_out, 1);
        chk("t4_pre_data", ref_tdata_out, 16'h103);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("t4_ab_valid", ref_tvalid_out, 0);
        chk("t4_ab_state", dbg_state, 0);
        chk("t4_ab_busy", busy_out, 0);
        chk("t4_ab_done", done_out, 0);
        ref_tready_in = 1'b1;
        extra = dones;
        for (int k = 0; k < 5; k++) begin
            if (ref_tvalid_out || done_out) extra++;
            tick();
        end
        chk("t4_ab_quiet", extra, 0);
        do_start(4, 1'b1);
        run(40, 1'b0);
        chk_beats("t4_restart", 4);
        chk("t4_restart_first", first_k, 4);

        // 5: clamp len to 2^PW
        do_start(16 + 5, 1'b1);
        chk("t5_lenerr_k1", len_err_out, 1);
        run(80, 1'b0);
        chk_beats("t5", 16);
        chk("t5_last_addr", ref_addr_out, 15);
        chk("t5_lenerr_sticky", len_err_out, 1);
        tick();
        do_start(3, 1'b1);
        chk("t5_lenerr_clr", len_err_out, 0);
        run(40, 1'b0);
        chk_beats("t5_after", 3);

        // 6: asynchronous reset mid-stream
        do_start(8, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        chk("t6_pre_valid", ref_tvalid_out, 1);
        #2 rst_in = 1'b1;
        #1;
        chk("t6_rst_tvalid", ref_tvalid_out, 0);
        chk("t6_rst_tdata", ref_tdata_out, 0);
        chk("t6_rst_tlast", ref_tlast_out, 0);
        chk("t6_rst_busy", busy_out, 0);
        chk("t6_rst_state", dbg_state, 0);
        chk("t6_rst_addr", ref_addr_out, 0);
        chk("t6_rst_done", done_out, 0);
        #2 rst_in = 1'b0;
        tick();
        do_start(3, 1'b1);
        run(40, 1'b0);
        chk_beats("t6_after", 3);
        chk("t6_first_k", first_k, 4);

        chk("fifo_overflow", ovf, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dtw_ref_streamer.md
Name: dtw_ref_streamer

Overview:
- Downstream consumer of the DTW reference memory.
- During DTW read mode it drives the reference-memory read address and absorbs the memory read latency.
- It re-presents reference samples 0..ref_len-1 as a valid/ready stream with a last marker, one full sweep per start pulse, to the DTW processing-element array.
- Credit-based issue with an output FIFO gives full throughput under arbitrary backpressure.

Parameters:
- DATA_WIDTH, 16, reference sample width.
- ADDR_WIDTH, 32, width of ref_len_in (AXI register width).
- REFMEM_PTR_WIDTH, 20, reference-memory address width.
- MEM_LATENCY, 2, cycles from ref_addr_out change to matching ref_data_in (1 registered address + 1 registered RAM output); legal range 1..4.
- FIFO_DEPTH, 4, output FIFO entries; must be >= MEM_LATENCY+1 (elaboration error otherwise).

Ports:
- clk_in, in, 1, clock.
- rst_in, in, 1, asynchronous active-high reset.
- start_in, in, 1, one-cycle pulse: begin one reference sweep.
- abort_in, in, 1, cancel the sweep in progress.
- ref_ready_in, in, 1, reference loaded (ref_load_done from the reference core, held by top level).
- ref_len_in, in, ADDR_WIDTH, number of reference samples.
- ref_addr_out, out, REFMEM_PTR_WIDTH, reference-memory read address.
- ref_data_in, in, DATA_WIDTH, reference-memory read data.
- ref_tdata_out, out, DATA_WIDTH, stream sample.
- ref_tvalid_out, out, 1, stream valid.
- ref_tready_in, in, 1, stream ready.
- ref_tlast_out, out, 1, final sample of the sweep.
- busy_out, out, 1, sweep in progress.
- done_out, out, 1, one-cycle pulse: sweep complete.
- len_err_out, out, 1, sticky: ref_len exceeded 2^REFMEM_PTR_WIDTH and was clamped; cleared on the next accepted start.
- dbg_state, out, 2, FSM state.

Behaviour:
- Reset (async assert, sync deassert use): state IDLE; all outputs 0; FIFO empty; in-flight pipeline cleared.
- Only already-decided interface fact: one clock; reset is asynchronous and active-high (rst_in).
- FSM states: IDLE=0, STREAM=1, DRAIN=2.
- IDLE: start_in && ref_ready_in -> latch len = min(ref_len_in, 2^REFMEM_PTR_WIDTH), set len_err_out if clamped, clear issue counter, go STREAM, busy_out=1 next cycle.
- IDLE: start_in with ref_ready_in=0 is ignored.
- IDLE: start with latched len=0 -> done_out pulses the next cycle, no beats, stays IDLE.
- start_in outside IDLE is ignored.
- Issue: in STREAM, the next address is issued in a cycle when (fifo_count + inflight) < FIFO_DEPTH.
  - ref_addr_out = issue counter (registered); counter increments on each issue.
  - A 1-bit valid token enters a MEM_LATENCY shift register; when it emerges, ref_data_in is written to the FIFO.
  - ref_addr_out holds its last value when not issuing.
- Last issue (counter == len-1) -> DRAIN.
- tlast: marks the FIFO entry whose index is len-1. It is carried as a FIFO sideband bit, not recomputed.
- Output: FIFO is first-word-fall-through. ref_tvalid_out = !empty. A beat transfers when tvalid && tready.
  - tdata/tlast stable while valid && !ready.
  - Simultaneous FIFO write and read in one cycle is legal; count is unchanged.
- Credit rule guarantees no FIFO overflow. Overflow would be a design bug; the bench asserts it never occurs.
- DRAIN: when FIFO empty and inflight==0 (the tlast beat has transferred) -> done_out pulse for 1 cycle, busy_out=0, state IDLE in the same cycle.
- Throughput: 1 beat/cycle when tready held high. First tvalid appears MEM_LATENCY+1 cycles after the start pulse.
- abort_in in STREAM/DRAIN:
  - Next cycle: FIFO flushed, in-flight tokens discarded, tvalid=0, state IDLE, no done_out.
  - This is the only case where tvalid drops without a transfer.
  - abort_in in IDLE has no effect.
  - Abort and start in the same cycle: abort wins; start is ignored.
- Counters are REFMEM_PTR_WIDTH+1 bits so len = 2^PTR_WIDTH issues addresses 0..2^PTR_WIDTH-1 without wrap.
- ref_len_in and ref_ready_in changes mid-sweep are ignored (len latched). ref_ready_in is sampled only at start.
- Reset mid-sweep: immediate return to reset values. Partial data is lost.

Test Plan:
- Memory preloaded with mem[i]=0x100+i, len=5, tready=1, start -> beats 0x100..0x104 on consecutive cycles, first at start+3 (latency 2), tlast only on 0x104, done_out one cycle after the last beat, busy 1 throughout.
- len=12, tready random 50% -> all 12 values in order with no duplicates or drops, tdata stable while stalled, no FIFO overflow assertion fires, exactly one done_out pulse.
- len=0 start -> no tvalid, done_out pulse next cycle. start with ref_ready_in=0 -> nothing, busy stays 0.
- len=8, tready=0 after 3 beats, abort_in at cycle 10 -> tvalid=0 next cycle, state IDLE, no done_out. A new start then streams 0x100.. from address 0.
- ref_len_in = 2^REFMEM_PTR_WIDTH+5 (bench with REFMEM_PTR_WIDTH=4) -> 16 beats, last address 15, len_err_out=1, cleared on the next valid start.
- rst_in asserted mid-STREAM asynchronously -> all outputs 0 without a clock edge. After release, a fresh sweep of len=3 is correct.
